// File: rtl/rom_stream_loader_pkg.sv
// rom_stream_loader_pkg: shared state type, sizing helpers and pad mask for the ROM boot loader
package rom_stream_loader_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
    localparam int LANE_W = 4;
    function automatic int words_for(input int rom_size, input int word_bytes);
        return (rom_size + word_bytes - 1) / word_bytes;
    endfunction
    function automatic int cnt_width(input int rom_size);
        return $clog2(rom_size) + 1;
    endfunction
    localparam int ROM_SIZE_DEF = 165;
    localparam int WORD_BYTES_DEF = 4;
    localparam int WORDS = words_for(ROM_SIZE_DEF, WORD_BYTES_DEF);
    localparam int CNT_W = cnt_width(ROM_SIZE_DEF);
    // one bit per filled lane; lanes at or above the fill count read as zero
    function automatic logic [7:0] pad_mask(input logic [LANE_W-1:0] lanes);
        return 8'((9'd1 << lanes) - 9'd1);
    endfunction
endpackage

// File: rtl/rom_stream_loader_byte_packer.sv
// byte_packer: little-endian lane register with load-at-lane, clear and zero-padded output
module byte_packer
    import rom_stream_loader_pkg::*;
#(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic [LANE_W-1:0]       lane,
    input  logic [7:0]              byte_in,
    output logic [8*WORD_BYTES-1:0] word
);
    logic [8*WORD_BYTES-1:0] lanes_q;
    logic [WORD_BYTES-1:0] mask;
    assign mask = WORD_BYTES'(pad_mask(lane));
    always_ff @(posedge clock) begin
        if (reset || clear) lanes_q <= '0;
        else if (load) lanes_q[8*lane +: 8] <= byte_in;
    end
    for (genvar k = 0; k < WORD_BYTES; k++) begin : g_lane
        assign word[8*k +: 8] = mask[k] ? lanes_q[8*k +: 8] : 8'h00;
    end
endmodule

// File: rtl/rom_stream_loader.sv
// rom_stream_loader: copies a combinational byte ROM into memory as packed words over valid/ready
module rom_stream_loader
    import rom_stream_loader_pkg::*;
#(
    parameter int ROM_SIZE = 165,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic [ADDR_WIDTH-1:0]   rom_address,
    input  logic [7:0]              rom_byte,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [8*WORD_BYTES-1:0] mem_data,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              checksum
);
    localparam int CW = cnt_width(ROM_SIZE);
    state_t state, next;
    logic [CW-1:0] counter, word_index;
    logic [LANE_W-1:0] lane;
    logic [ADDR_WIDTH-1:0] rom_hold;
    logic [7:0] sum;
    logic [8*WORD_BYTES-1:0] packed_word;
    logic load_start, accept, fetch_end;
    assign load_start = start && (state == IDLE || state == DONE);
    assign accept = state == WRITE && mem_ready;
    assign fetch_end = lane == LANE_W'(WORD_BYTES - 1) || counter == CW'(ROM_SIZE - 1);
    always_comb begin
        next = state;
        unique case (state)
            IDLE, DONE: next = start ? FETCH : state;
            FETCH:      next = fetch_end ? WRITE : FETCH;
            WRITE:      next = !mem_ready ? WRITE : (counter == CW'(ROM_SIZE)) ? DONE : FETCH;
            default:    next = IDLE;
        endcase
        rom_address = state == FETCH ? ADDR_WIDTH'(counter) : rom_hold;
        mem_valid = state == WRITE;
        mem_address = mem_valid ? BASE_ADDR + ADDR_WIDTH'(word_index) * ADDR_WIDTH'(WORD_BYTES) : '0;
        mem_data = mem_valid ? packed_word : '0;
        busy = state == FETCH || state == WRITE;
        done = state == DONE;
        checksum = sum;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            counter <= '0;
            word_index <= '0;
            lane <= '0;
            sum <= '0;
            rom_hold <= '0;
        end else begin
            state <= next;
            if (load_start) begin
                counter <= '0;
                word_index <= '0;
                lane <= '0;
                sum <= '0;
            end else if (state == FETCH) begin
                counter <= counter + 1'b1;
                lane <= lane + 1'b1;
                sum <= sum + rom_byte;
                rom_hold <= rom_address;
            end else if (accept) begin
                word_index <= word_index + 1'b1;
                lane <= '0;
            end
        end
    end
    byte_packer #(.WORD_BYTES(WORD_BYTES)) u_packer (
        .clock(clock),
        .reset(reset),
        .clear(load_start || accept),
        .load(state == FETCH),
        .lane(lane),
        .byte_in(rom_byte),
        .word(packed_word)
    );
endmodule

// File: tb/tb_rom_stream_loader.sv
// tb_rom_stream_loader: scoreboard bench for the ROM boot loader (10-byte ROM, 4-byte words, base 0x100)
module tb_rom_stream_loader;
    localparam int ROM_SIZE = 10;
    localparam int WB = 4;
    localparam int AW = 32;
    localparam logic [AW-1:0] BASE = 32'h100;
    localparam int WORDS = (ROM_SIZE + WB - 1) / WB;
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [8*WB-1:0] data;
    } wr_t;
    logic clock = 0, reset = 1, start = 0, mem_ready = 1;
    logic [AW-1:0] rom_address, mem_address;
    logic [7:0] rom_byte, checksum;
    logic [8*WB-1:0] mem_data;
    logic mem_valid, busy, done;
    logic [7:0] rom_mem [ROM_SIZE];
    wr_t exp_q[$];
    wr_t e_w;
    int checks = 0, errors = 0, wait_cnt = 0;
    bit bp = 0;
    logic [AW-1:0] hold_addr, hold_rom;
    logic [8*WB-1:0] hold_data;
    logic [7:0] sum;

    rom_stream_loader #(.ROM_SIZE(ROM_SIZE), .WORD_BYTES(WB), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .start(start),
        .rom_address(rom_address), .rom_byte(rom_byte),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clock = ~clock;
    assign rom_byte = (rom_address < ROM_SIZE) ? rom_mem[int'(rom_address)] : 8'h00;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // write monitor: optional 5-cycle stall per word, stability checks, scoreboard pop on acceptance
    always @(negedge clock) begin
        if (reset) begin
            wait_cnt = 0;
            mem_ready = !bp;
        end else if (mem_valid) begin
            if (wait_cnt == 0) begin
                hold_addr = mem_address;
                hold_data = mem_data;
                hold_rom = rom_address;
            end else begin
                check("hold_addr", mem_address, hold_addr);
                check("hold_data", mem_data, hold_data);
                check("hold_rom", rom_address, hold_rom);
            end
            if (bp && wait_cnt < 5) begin
                mem_ready = 0;
                wait_cnt++;
            end else begin
                mem_ready = 1;
                wait_cnt = 0;
                if (exp_q.size() == 0) check("extra_write", mem_address, 64'hdead);
                else begin
                    e_w = exp_q.pop_front();
                    check("wr_addr", mem_address, e_w.addr);
                    check("wr_data", mem_data, e_w.data);
                end
            end
        end else mem_ready = !bp;
    end

    task automatic fill_rom(input int mode);
        for (int i = 0; i < ROM_SIZE; i++) rom_mem[i] = mode == 0 ? 8'(i + 1) : 8'($urandom);
    endtask

    task automatic push_expect(output logic [7:0] s);
        wr_t w;
        s = 0;
        for (int i = 0; i < ROM_SIZE; i++) s += rom_mem[i];
        for (int k = 0; k < WORDS; k++) begin
            w.addr = BASE + 32'(k * WB);
            w.data = '0;
            for (int b = 0; b < WB; b++)
                if (k * WB + b < ROM_SIZE) w.data[8*b +: 8] = rom_mem[k * WB + b];
            exp_q.push_back(w);
        end
    endtask

    task automatic run_load(input string tag, input bit poke);
        int cyc;
        push_expect(sum);
        @(posedge clock); #1 start = 1;
        @(posedge clock); #1 start = 0;
        check({tag, "_busy0"}, busy, 1);
        check({tag, "_done0"}, done, 0);
        cyc = 0;
        while (busy && cyc < 1000) begin
            if (poke && cyc == 3) start = 1;
            cyc++;
            @(posedge clock); #1 start = 0;
        end
        check({tag, "_cycles"}, cyc, ROM_SIZE + WORDS * (bp ? 6 : 1));
        check({tag, "_done"}, done, 1);
        check({tag, "_sum"}, checksum, sum);
        check({tag, "_romhold"}, rom_address, ROM_SIZE - 1);
        repeat (4) @(posedge clock);
        #1 check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_idle_valid"}, mem_valid, 0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 check("rst_valid", mem_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", checksum, 0);
        check("rst_rom", rom_address, 0);
        check("rst_maddr", mem_address, 0);
        check("rst_mdata", mem_data, 0);
        reset = 0;
        fill_rom(0);
        run_load("inc", 0);
        check("inc_sum_const", checksum, 8'd55);
        fill_rom(1);
        bp = 1;
        run_load("bp", 0);
        fill_rom(1);
        push_expect(sum);
        @(posedge clock); #1 start = 1;
        @(posedge clock); #1 start = 0;
        for (int i = 0; i < 100 && !mem_valid; i++) @(negedge clock);
        check("mid_valid_seen", mem_valid, 1);
        @(posedge clock); #1 reset = 1;
        @(posedge clock); #1;
        check("mid_rst_valid", mem_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sum", checksum, 0);
        reset = 0;
        exp_q.delete();
        bp = 0;
        repeat (2) @(posedge clock);
        fill_rom(1);
        run_load("reload", 0);
        run_load("poke", 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_stream_loader.md
Name: rom_stream_loader

Overview:
- Sequential boot loader. Walks an external combinational byte ROM (generated by the ROM generator) from byte 0 to ROM_SIZE-1.
- Packs bytes little-endian into WORD_BYTES-wide words and writes them into main memory over a valid/ready write port, starting at BASE_ADDR.
- Sits between the generated ROM and the CPU's memory bus. Holds the core in reset until `done`.
- Successor to the fixed-length byte ROM: length, word width and destination are parametrised, and it adds handshaking, padding, a checksum and restart.

Parameters:
- ROM_SIZE, 165, number of valid ROM bytes (>=1)
- WORD_BYTES, 4, bytes per memory write (1, 2, 4 or 8)
- ADDR_WIDTH, 32, width of ROM and memory addresses
- BASE_ADDR, 0, memory byte address of the first written word (WORD_BYTES-aligned)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a load; ignored while busy
- rom_address  out  ADDR_WIDTH  byte address presented to the ROM
- rom_byte  in  8  ROM data, combinational from rom_address, same cycle
- mem_address  out  ADDR_WIDTH  byte address of the current write
- mem_data  out  8*WORD_BYTES  packed word; byte k in bits [8k+7:8k]
- mem_valid  out  1  write request
- mem_ready  in  1  memory accepts when mem_valid & mem_ready
- busy  out  1  load in progress
- done  out  1  sticky; high after the last word is accepted
- checksum  out  8  mod-256 sum of all ROM bytes read in this load

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0; lane 0; packing register 0. Reset in any state aborts the load immediately. mem_valid drops in the same edge, with no partial write.
- States: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - start=1 → FETCH.
  - Clears counter, lane, checksum and the packing register.
  - Clears done. busy=1 from the next cycle.
- FETCH:
  - rom_address = counter. Each cycle, rom_byte is latched into lane `lane` of the packing register.
  - checksum += rom_byte, 8-bit wrap. counter++, lane++.
  - If lane==WORD_BYTES-1 or counter==ROM_SIZE-1 → WRITE.
  - One byte per cycle. No ROM wait states.
- WRITE:
  - mem_valid=1. mem_data = packing register, with unfilled lanes 0 (zero-padding of the final partial word).
  - mem_address = BASE_ADDR + word_index*WORD_BYTES.
  - mem_data and mem_address are stable while mem_valid & !mem_ready. mem_valid is never withdrawn before acceptance.
  - On acceptance: word_index++, lane=0, packing register cleared. If all ROM_SIZE bytes are consumed → DONE, else → FETCH.
  - mem_valid deasserts in the cycle after acceptance.
- DONE:
  - done=1, busy=0, checksum holds.
  - start=1 → restart a full load, as from IDLE (done clears next cycle).
- rom_address is held at its last value outside FETCH.
- start during FETCH/WRITE is ignored. No queuing.
- Throughput with mem_ready tied 1: WORD_BYTES+1 cycles per full word.
- Total words = ceil(ROM_SIZE/WORD_BYTES). Counters are sized $clog2(ROM_SIZE)+1 bits. mem_address arithmetic wraps modulo 2^ADDR_WIDTH.
- ROM_SIZE < WORD_BYTES: single padded write.

Decomposition:
- Shared package:
  - loader state enum (IDLE, FETCH, WRITE, DONE)
  - localparams WORDS = ceil(ROM_SIZE/WORD_BYTES), CNT_W
  - a function computing the zero-pad mask from the final lane count
- One natural sub-module: `byte_packer`. Lane register with load-at-lane, clear and zero-pad output. Parametrised by WORD_BYTES.

Test Plan:
1. ROM_SIZE=8, WORD_BYTES=4, ROM bytes 1..8, mem_ready=1, start pulse.
   → Writes 0x04030201 @0 and 0x08070605 @4; done after 10 busy cycles; checksum=36.
2. ROM_SIZE=165 with the current generated program, WORD_BYTES=4.
   → 42 writes; last write @164 = 0x00000000 (byte 164 = 0, plus 3 padded lanes).
   → checksum equals the mod-256 sum of the ROM image.
3. ROM_SIZE=6, WORD_BYTES=4, bytes 0xAA..0xAF, BASE_ADDR=0x100.
   → 0xADACABAA @0x100, then 0x0000AFAE @0x104 (zero-padded).
4. Back-pressure: mem_ready low for 5 cycles on each write.
   → mem_valid/mem_data/mem_address stable throughout; no ROM advance; same final data as case 1.
5. Reset asserted mid-WRITE with mem_valid high.
   → Next edge: mem_valid=0, busy=0, done=0, checksum=0.
   → A subsequent start reloads from byte 0 correctly.
6. start pulsed during busy, then again in DONE.
   → First pulse ignored (no extra writes). Second pulse repeats the full write sequence; done low for the load duration.
